// File: rtl/mask_pkg.sv
// Shared types and defaults for the Mask engine frame scheduler.
package mask_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENGRST,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNDERRUN = 2'b01;
    localparam logic [1:0] ERR_TMO      = 2'b10;

    localparam int DW_DEF      = 8;
    localparam int N_BYTES_DEF = 256;
    localparam int N_OUT_DEF   = 256;

endpackage

// File: rtl/mask_sched_if.sv
// Source streams, engine bus and result stream of the Mask scheduler.
interface mask_sched_if
    import mask_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic [1:0]    req;
    logic [DW-1:0] s0_data;
    logic          s0_valid;
    logic          s0_ready;
    logic [DW-1:0] s1_data;
    logic          s1_valid;
    logic          s1_ready;
    logic          eng_rst;
    logic [DW-1:0] eng_din;
    logic          eng_busy;
    logic [DW-1:0] eng_dout;
    logic          eng_ovalid;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_src;
    logic          m_last;
    logic          frame_done;
    logic          err;
    logic [1:0]    err_code;

    modport master (
        input  req, s0_data, s0_valid, s1_data, s1_valid,
        input  eng_busy, eng_dout, eng_ovalid,
        output s0_ready, s1_ready, eng_rst, eng_din,
        output m_data, m_valid, m_src, m_last,
        output frame_done, err, err_code
    );

    modport slave (
        output req, s0_data, s0_valid, s1_data, s1_valid,
        output eng_busy, eng_dout, eng_ovalid,
        input  s0_ready, s1_ready, eng_rst, eng_din,
        input  m_data, m_valid, m_src, m_last,
        input  frame_done, err, err_code
    );
endinterface

// File: rtl/mask_rr_arb2.sv
// Two-way round-robin source pick; pointer moves to the other source at frame end.
module mask_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       grant,
    output logic       pick
);
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (upd) begin
            rr_ptr <= ~grant;
        end
    end

    // The pointer only matters when both sources contend.
    assign pick = (&req) ? rr_ptr : req[1];
endmodule

// File: rtl/mask_sched.sv
// Frame scheduler sharing one Mask engine between two byte sources.
// Optional watchdog abort is enabled by defining MASK_SCHED_TMO_EN.
module mask_sched
    import mask_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int N_BYTES = N_BYTES_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int CNT_W   = 9,
    parameter int TMO     = 1024
) (
    input logic          clk,
    input logic          rst,
    mask_sched_if.master bus
);
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(N_OUT - 1);

    state_t           state;
    logic             grant;
    logic             pick;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             eng_rst_r;
    logic             done_r;
    logic             err_r;
    logic [1:0]       code_r;

    logic             load;
    logic             in_frame;
    logic             src_valid;
    logic [DW-1:0]    src_data;
    logic             ready;
    logic             accept;
    logic             underrun;
    logic             result;
    logic             last;
    logic             tmo_hit;
    logic             abort;
    logic             rr_upd;

    assign load      = (state == LOAD);
    assign in_frame  = load | (state == DRAIN);
    assign src_valid = grant ? bus.s1_valid : bus.s0_valid;
    assign src_data  = grant ? bus.s1_data : bus.s0_data;
    assign ready     = load & ~bus.eng_busy;
    assign accept    = ready & src_valid;
    assign underrun  = ready & ~src_valid;
    assign result    = in_frame & bus.eng_ovalid;
    assign last      = result & (out_cnt == LAST_OUT);
    // A completed frame wins over a same-cycle abort condition.
    assign abort     = ~last & (underrun | tmo_hit);
    assign rr_upd    = (state == DONE) | abort;

    assign bus.s0_ready   = ready & ~grant;
    assign bus.s1_ready   = ready & grant;
    assign bus.eng_din    = accept ? src_data : '0;
    assign bus.eng_rst    = rst | eng_rst_r;
    assign bus.m_valid    = result;
    assign bus.m_data     = result ? bus.eng_dout : '0;
    assign bus.m_src      = grant;
    assign bus.m_last     = last;
    assign bus.frame_done = done_r;
    assign bus.err        = err_r;
    assign bus.err_code   = code_r;

    mask_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.req),
        .upd   (rr_upd),
        .grant (grant),
        .pick  (pick)
    );

`ifdef MASK_SCHED_TMO_EN
    localparam int WD_W = $clog2(TMO + 1);

    logic [WD_W-1:0] wd_cnt;

    // Idle cycles since the last accepted byte or result.
    always_ff @(posedge clk) begin
        if (rst || !in_frame || accept || result) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign tmo_hit = in_frame & ~accept & ~result &
                     (wd_cnt == WD_W'(TMO - 1));
`else
    assign tmo_hit = (TMO == 0) & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            eng_rst_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            code_r    <= ERR_NONE;
        end else begin
            eng_rst_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            if (accept && in_cnt != '1) begin
                in_cnt <= in_cnt + 1'b1;
            end
            if (result && out_cnt != '1) begin
                out_cnt <= out_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant     <= pick;
                        eng_rst_r <= 1'b1;
                        state     <= ENGRST;
                    end
                end
                ENGRST: begin
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    state   <= LOAD;
                end
                LOAD, DRAIN: begin
                    if (last) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else if (abort) begin
                        err_r     <= 1'b1;
                        code_r    <= tmo_hit ? ERR_TMO : ERR_UNDERRUN;
                        eng_rst_r <= 1'b1;
                        state     <= IDLE;
                    end else if (accept && in_cnt == LAST_IN) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
